matmul_job_sched: RTL and testbench
===================================

// Module: matmul_job_sched
// PURPOSE
//  Job scheduler in front of one matmul engine. Queues matrix-multiply descriptors from a host
//  (valid/ready), launches them in order via go/ret, holds each descriptor stable while the engine
//  runs, reports per-job completion. Rejects zero-dimension jobs; runs a watchdog on each job.
// PARAMETERS
//  MEM_AW    16  address width of base fields (matches engine)
//  DIM_BITS  16  width of stride/dimension fields (matches engine)
//  DEPTH     4   descriptor FIFO entries; power of 2, >=2
//  TAG_W     4   host job tag width
//  TMO_CYC   0   watchdog limit in BUSY cycles; 0 disables
// PORTS
//  clk        in   1         clock
//  rst_n      in   1         synchronous active-low reset
//  s_valid    in   1         descriptor valid
//  s_ready    out  1         descriptor accepted when s_valid&s_ready
//  s_tag      in   TAG_W     job tag
//  s_abase/s_bbase/s_cbase         in  MEM_AW    matrix base addresses
//  s_astride/s_bstride/s_cstride   in  DIM_BITS  row strides
//  s_arows/s_acols/s_bcols         in  DIM_BITS  dimensions
//  enable     in   1         0 = launch no new jobs; the running job finishes
//  mm_go      out  1         engine start, one-cycle pulse
//  mm_ret     in   1         engine done, one-cycle pulse
//  mm_abase..mm_bcols  out   as s_*  FIFO head descriptor to engine (9 fields)
//  done_vld   out  1         one-cycle completion pulse
//  done_tag   out  TAG_W     tag of completed job
//  done_err   out  1         1 = job skipped (zero dimension)
//  busy       out  1         state != IDLE
//  q_level    out  log2(DEPTH)+1  FIFO occupancy
//  tmo_err    out  1         sticky watchdog flag
// BEHAVIOUR
//  Reset: FIFO emptied, ptrs/count 0, state IDLE, tmo_err=0, watchdog=0. All outputs 0 except
//   s_ready=1. Reset mid-job drops all queued work; engine shares rst_n.
//  FIFO: s_ready = (count<DEPTH). Push on s_valid&s_ready. Pop only in DONE/SKIP. Push and pop in
//   the same cycle: both occur, count unchanged. Pointers wrap modulo DEPTH. Push when full is ignored.
//  mm_* fields come from the head entry. They are stable from LAUNCH through the DONE cycle because
//   pushes never alter the head. q_level = count.
//  FSM (registered state):
//   IDLE:   count!=0 & enable & any of head arows/acols/bcols==0 -> SKIP;
//           count!=0 & enable & otherwise -> LAUNCH; else stay.
//   LAUNCH: mm_go=1 this cycle only; watchdog cleared -> BUSY.
//   BUSY:   watchdog += 1 (saturating); mm_ret -> DONE.
//   DONE:   done_vld=1, done_err=0, done_tag=head tag, pop -> IDLE.
//   SKIP:   done_vld=1, done_err=1, done_tag=head tag, pop, no mm_go -> IDLE.
//  mm_go and done_* decode from the state register (glitch-free); done_tag/done_err are 0 when
//   done_vld=0.
//  Spacing: mm_go rises >=2 cycles after mm_ret. After reset release, first mm_go is no earlier
//   than cycle 2. Both keep the engine in its wait-for-go state when go is sampled.
//  mm_ret outside BUSY: ignored.
//  enable dropping in LAUNCH/BUSY does not abort the job.
//  Watchdog: TMO_CYC!=0 and watchdog==TMO_CYC in BUSY -> tmo_err=1, sticky until reset. The job keeps
//   waiting; a late mm_ret completes it normally.
// TESTING
//  T1 Reset release; cycle0 push tag=3, 2x2x2 (arows=acols=bcols=2) -> mm_go=1 only at cycle 2;
//     mm_* hold the pushed values until done. Drive mm_ret at cycle 20 -> done_vld=1 at cycle 21,
//     tag=3, err=0.
//  T2 DEPTH=4: push tags 0..4 back-to-back with engine busy -> s_ready=0 once q_level=4; tag 4 held
//     off until first pop. Completions arrive in order 0,1,2,3,4; consecutive mm_go >=2 cycles after
//     each mm_ret.
//  T3 Push acols=0 tag=7 -> no mm_go; done_vld with done_err=1, tag=7, 2 cycles after push; q_level
//     returns to 0.
//  T4 enable=0; push 2 jobs -> no mm_go, q_level=2. Set enable=1 -> mm_go 1 cycle later. Clear enable
//     during BUSY -> job completes, second job not launched.
//  T5 TMO_CYC=100, withhold mm_ret -> tmo_err rises on the 100th BUSY cycle and stays 1. mm_ret at
//     cycle 150 -> done_vld, err=0; tmo_err still 1.
//  T6 rst_n=0 during BUSY with 3 queued -> next cycle: all outputs 0, s_ready=1, q_level=0. No
//     done_vld for dropped jobs.

Source files
------------

// File: rtl/matmul_job_sched_if.sv
// Host / engine / status bundle for matmul_job_sched.
//  slave  : scheduler side (accepts descriptors, drives the engine, reports status)
//  master : host + engine side (pushes descriptors, returns mm_ret, sets enable)
//  s_*     : descriptor push (valid/ready), tag, three bases, three strides, three dimensions
//  enable  : 0 holds off new launches
//  mm_*    : engine go/ret handshake and the head descriptor held toward the engine
//  done_*  : per-job completion pulse, tag and skip flag
//  busy/q_level/tmo_err : status
interface matmul_job_sched_if #(
    parameter int unsigned MEM_AW   = 16,
    parameter int unsigned DIM_BITS = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TAG_W    = 4
);
    localparam int unsigned QL_W = $clog2(DEPTH) + 1;

    logic                s_valid;
    logic                s_ready;
    logic [TAG_W-1:0]    s_tag;
    logic [MEM_AW-1:0]   s_abase, s_bbase, s_cbase;
    logic [DIM_BITS-1:0] s_astride, s_bstride, s_cstride;
    logic [DIM_BITS-1:0] s_arows, s_acols, s_bcols;

    logic                enable;

    logic                mm_go;
    logic                mm_ret;
    logic [MEM_AW-1:0]   mm_abase, mm_bbase, mm_cbase;
    logic [DIM_BITS-1:0] mm_astride, mm_bstride, mm_cstride;
    logic [DIM_BITS-1:0] mm_arows, mm_acols, mm_bcols;

    logic                done_vld;
    logic [TAG_W-1:0]    done_tag;
    logic                done_err;
    logic                busy;
    logic [QL_W-1:0]     q_level;
    logic                tmo_err;

    modport slave (
        input  s_valid, s_tag, s_abase, s_bbase, s_cbase,
               s_astride, s_bstride, s_cstride, s_arows, s_acols, s_bcols,
               enable, mm_ret,
        output s_ready, mm_go,
               mm_abase, mm_bbase, mm_cbase, mm_astride, mm_bstride, mm_cstride,
               mm_arows, mm_acols, mm_bcols,
               done_vld, done_tag, done_err, busy, q_level, tmo_err
    );

    modport master (
        output s_valid, s_tag, s_abase, s_bbase, s_cbase,
               s_astride, s_bstride, s_cstride, s_arows, s_acols, s_bcols,
               enable, mm_ret,
        input  s_ready, mm_go,
               mm_abase, mm_bbase, mm_cbase, mm_astride, mm_bstride, mm_cstride,
               mm_arows, mm_acols, mm_bcols,
               done_vld, done_tag, done_err, busy, q_level, tmo_err
    );
endinterface

// File: rtl/matmul_job_sched.sv
// Job scheduler in front of one matmul engine: queues descriptors in a DEPTH-entry FIFO,
// launches them in order with a one-cycle mm_go, waits for mm_ret, reports completion.
// Zero-dimension jobs are skipped with done_err=1. A per-job watchdog sets sticky tmo_err.
// Ports:
//  clk   : clock
//  rst_n : synchronous active-low reset (drops all queued work)
//  bus   : matmul_job_sched_if.slave (descriptor push, engine handshake, status)
module matmul_job_sched #(
    parameter int unsigned MEM_AW   = 16,
    parameter int unsigned DIM_BITS = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned TMO_CYC  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    matmul_job_sched_if.slave    bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WD_W  = $clog2(TMO_CYC + 2);

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [MEM_AW-1:0]   abase;
        logic [MEM_AW-1:0]   bbase;
        logic [MEM_AW-1:0]   cbase;
        logic [DIM_BITS-1:0] astride;
        logic [DIM_BITS-1:0] bstride;
        logic [DIM_BITS-1:0] cstride;
        logic [DIM_BITS-1:0] arows;
        logic [DIM_BITS-1:0] acols;
        logic [DIM_BITS-1:0] bcols;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_BUSY   = 3'd2,
        S_DONE   = 3'd3,
        S_SKIP   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    desc_t            mem_q [DEPTH];
    desc_t            in_desc, head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             tmo_q, tmo_d;
    logic             push, pop, zero_dim;

    // Incoming descriptor packing
    always_comb begin
        in_desc.tag     = bus.s_tag;
        in_desc.abase   = bus.s_abase;
        in_desc.bbase   = bus.s_bbase;
        in_desc.cbase   = bus.s_cbase;
        in_desc.astride = bus.s_astride;
        in_desc.bstride = bus.s_bstride;
        in_desc.cstride = bus.s_cstride;
        in_desc.arows   = bus.s_arows;
        in_desc.acols   = bus.s_acols;
        in_desc.bcols   = bus.s_bcols;
    end

    // Head is forced to zero while empty so reset leaves mm_* at 0 without clearing storage
    assign head     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign zero_dim = (head.arows == '0) || (head.acols == '0) || (head.bcols == '0);

    assign bus.s_ready = (count_q < CNT_W'(DEPTH));
    assign push        = bus.s_valid && bus.s_ready;
    assign pop         = (state_q == S_DONE) || (state_q == S_SKIP);

    // Descriptor storage; pushes only touch the tail so the head stays stable during a job
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_desc;
        end
    end

    // FIFO pointers, occupancy and watchdog next-state
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        wdog_d   = wdog_q;
        if (state_q == S_LAUNCH) begin
            wdog_d = '0;
        end else if ((state_q == S_BUSY) && (wdog_q != '1)) begin
            wdog_d = wdog_q + WD_W'(1);
        end
        tmo_d = tmo_q || ((TMO_CYC != 0) && (state_q == S_BUSY) && (wdog_d == WD_W'(TMO_CYC)));
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wdog_q   <= '0;
            tmo_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wdog_q   <= wdog_d;
            tmo_q    <= tmo_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && bus.enable) begin
                    state_d = zero_dim ? S_SKIP : S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_BUSY;
            S_BUSY:   if (bus.mm_ret) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            S_SKIP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register
    always_comb begin
        bus.mm_go    = 1'b0;
        bus.done_vld = 1'b0;
        bus.done_err = 1'b0;
        bus.done_tag = '0;
        bus.busy     = (state_q != S_IDLE);
        case (state_q)
            S_LAUNCH: bus.mm_go = 1'b1;
            S_DONE: begin
                bus.done_vld = 1'b1;
                bus.done_tag = head.tag;
            end
            S_SKIP: begin
                bus.done_vld = 1'b1;
                bus.done_err = 1'b1;
                bus.done_tag = head.tag;
            end
            default: ;
        endcase
    end

    assign bus.mm_abase   = head.abase;
    assign bus.mm_bbase   = head.bbase;
    assign bus.mm_cbase   = head.cbase;
    assign bus.mm_astride = head.astride;
    assign bus.mm_bstride = head.bstride;
    assign bus.mm_cstride = head.cstride;
    assign bus.mm_arows   = head.arows;
    assign bus.mm_acols   = head.acols;
    assign bus.mm_bcols   = head.bcols;
    assign bus.q_level    = count_q;
    assign bus.tmo_err    = tmo_q;

endmodule

// File: tb/tb_matmul_job_sched.sv
// Directed bench for matmul_job_sched: reset, launch timing, FIFO full/ordering, zero-dim skip,
// enable gating, watchdog, and mid-job reset. Expected values are hand-derived constants.
module tb_matmul_job_sched;
    localparam int unsigned MEM_AW   = 16;
    localparam int unsigned DIM_BITS = 16;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned TMO_CYC  = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_job_sched_if #(.MEM_AW(MEM_AW), .DIM_BITS(DIM_BITS), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    matmul_job_sched #(
        .MEM_AW(MEM_AW), .DIM_BITS(DIM_BITS), .DEPTH(DEPTH), .TAG_W(TAG_W), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_ret_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_desc(input int tag, input int ar, input int ac, input int bc);
        bus.s_tag     = TAG_W'(tag);
        bus.s_abase   = 16'h1000 + 16'(tag);
        bus.s_bbase   = 16'h2000 + 16'(tag);
        bus.s_cbase   = 16'h3000 + 16'(tag);
        bus.s_astride = 16'h0010 + 16'(tag);
        bus.s_bstride = 16'h0020 + 16'(tag);
        bus.s_cstride = 16'h0030 + 16'(tag);
        bus.s_arows   = 16'(ar);
        bus.s_acols   = 16'(ac);
        bus.s_bcols   = 16'(bc);
    endtask

    // One-cycle push; waits (bounded) for s_ready, returns in the cycle after acceptance
    task automatic push(input int tag, input int ar, input int ac, input int bc);
        drive_desc(tag, ar, ac, bc);
        bus.s_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.s_ready; i++) tick();
        check("push_ready", longint'(bus.s_ready), 1);
        tick();
        bus.s_valid = 1'b0;
    endtask

    // Bounded wait for mm_go; checks head descriptor and go/ret spacing
    task automatic wait_go(input int tag);
        for (int i = 0; i < 200 && !bus.mm_go; i++) tick();
        check("go_seen", longint'(bus.mm_go), 1);
        check("go_abase", longint'(bus.mm_abase), longint'(16'h1000 + tag));
        check("go_cstride", longint'(bus.mm_cstride), longint'(16'h0030 + tag));
        check("go_gap_ge2", longint'((cyc - last_ret_cyc) >= 2), 1);
    endtask

    // Hold the engine busy for hold cycles, pulse mm_ret, check the completion
    task automatic finish(input int tag, input int hold);
        repeat (hold) tick();
        bus.mm_ret = 1'b1;
        last_ret_cyc = cyc;
        tick();
        bus.mm_ret = 1'b0;
        check("done_vld", longint'(bus.done_vld), 1);
        check("done_tag", longint'(bus.done_tag), longint'(tag));
        check("done_err", longint'(bus.done_err), 0);
    endtask

    initial begin
        int seen;
        bus.s_valid = 1'b0;
        bus.mm_ret  = 1'b0;
        bus.enable  = 1'b1;
        drive_desc(0, 0, 0, 0);

        // Reset state
        tick();
        tick();
        check("rst_s_ready", longint'(bus.s_ready), 1);
        check("rst_q_level", longint'(bus.q_level), 0);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_mm_go", longint'(bus.mm_go), 0);
        check("rst_tmo", longint'(bus.tmo_err), 0);
        check("rst_mm_abase", longint'(bus.mm_abase), 0);

        // T1: push at cycle 0, go at cycle 2, ret at 20, done at 21
        rst_n = 1'b1;
        drive_desc(3, 2, 2, 2);
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        check("t1_c1_go", longint'(bus.mm_go), 0);
        check("t1_c1_qlvl", longint'(bus.q_level), 1);
        tick();
        check("t1_c2_go", longint'(bus.mm_go), 1);
        check("t1_c2_abase", longint'(bus.mm_abase), 16'h1003);
        check("t1_c2_arows", longint'(bus.mm_arows), 2);
        tick();
        check("t1_c3_go", longint'(bus.mm_go), 0);
        check("t1_c3_busy", longint'(bus.busy), 1);
        repeat (17) tick();
        check("t1_c20_bbase", longint'(bus.mm_bbase), 16'h2003);
        check("t1_c20_cstride", longint'(bus.mm_cstride), 16'h0033);
        check("t1_c20_bcols", longint'(bus.mm_bcols), 2);
        finish(3, 0);
        tick();
        check("t1_c22_vld", longint'(bus.done_vld), 0);
        check("t1_c22_tag", longint'(bus.done_tag), 0);
        check("t1_c22_qlvl", longint'(bus.q_level), 0);

        // T2: fill the FIFO behind a running job, tag 4 held off, in-order completion
        push(0, 2, 2, 2);
        wait_go(0);
        push(1, 2, 2, 2);
        push(2, 2, 2, 2);
        push(3, 2, 2, 2);
        check("t2_full_qlvl", longint'(bus.q_level), 4);
        check("t2_full_ready", longint'(bus.s_ready), 0);
        drive_desc(4, 2, 2, 2);
        bus.s_valid = 1'b1;
        repeat (3) tick();
        check("t2_hold_ready", longint'(bus.s_ready), 0);
        check("t2_hold_qlvl", longint'(bus.q_level), 4);
        finish(0, 1);
        tick();
        check("t2_pop_ready", longint'(bus.s_ready), 1);
        check("t2_pop_qlvl", longint'(bus.q_level), 3);
        tick();
        bus.s_valid = 1'b0;
        check("t2_refill_qlvl", longint'(bus.q_level), 4);
        for (int t = 1; t <= 4; t++) begin
            wait_go(t);
            finish(t, 1 + t);
        end
        tick();
        check("t2_empty_qlvl", longint'(bus.q_level), 0);

        // T3: zero-dimension job is skipped two cycles after the push
        push(7, 2, 0, 2);
        check("t3_c1_go", longint'(bus.mm_go), 0);
        check("t3_c1_vld", longint'(bus.done_vld), 0);
        tick();
        check("t3_vld", longint'(bus.done_vld), 1);
        check("t3_err", longint'(bus.done_err), 1);
        check("t3_tag", longint'(bus.done_tag), 7);
        check("t3_go", longint'(bus.mm_go), 0);
        tick();
        check("t3_qlvl", longint'(bus.q_level), 0);
        check("t3_after_vld", longint'(bus.done_vld), 0);

        // T4: enable gating
        bus.enable = 1'b0;
        push(8, 3, 3, 3);
        push(9, 1, 1, 1);
        repeat (3) tick();
        check("t4_off_go", longint'(bus.mm_go), 0);
        check("t4_off_qlvl", longint'(bus.q_level), 2);
        check("t4_off_busy", longint'(bus.busy), 0);
        bus.enable = 1'b1;
        tick();
        check("t4_on_go", longint'(bus.mm_go), 1);
        check("t4_on_abase", longint'(bus.mm_abase), 16'h1008);
        tick();
        bus.enable = 1'b0;
        finish(8, 3);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.mm_go || bus.done_vld) seen++;
        end
        check("t4_no_launch", longint'(seen), 0);
        check("t4_left_qlvl", longint'(bus.q_level), 1);
        check("t4_idle_busy", longint'(bus.busy), 0);
        check("t4_tmo_clear", longint'(bus.tmo_err), 0);
        bus.enable = 1'b1;
        wait_go(9);
        finish(9, 1);

        // T5: watchdog trips at the end of BUSY cycle 100, job still completes
        push(10, 4, 4, 4);
        wait_go(10);
        tick();
        repeat (99) tick();
        check("t5_busy100_tmo", longint'(bus.tmo_err), 0);
        tick();
        check("t5_busy101_tmo", longint'(bus.tmo_err), 1);
        check("t5_still_busy", longint'(bus.busy), 1);
        check("t5_no_done", longint'(bus.done_vld), 0);
        repeat (48) tick();
        finish(10, 1);
        check("t5_tmo_sticky", longint'(bus.tmo_err), 1);
        repeat (3) tick();
        check("t5_tmo_sticky2", longint'(bus.tmo_err), 1);

        // T6: reset during BUSY with three queued behind the running job
        push(11, 2, 2, 2);
        push(12, 2, 2, 2);
        push(13, 2, 2, 2);
        push(14, 2, 2, 2);
        check("t6_pre_qlvl", longint'(bus.q_level), 4);
        check("t6_pre_busy", longint'(bus.busy), 1);
        rst_n = 1'b0;
        tick();
        check("t6_rst_ready", longint'(bus.s_ready), 1);
        check("t6_rst_qlvl", longint'(bus.q_level), 0);
        check("t6_rst_busy", longint'(bus.busy), 0);
        check("t6_rst_go", longint'(bus.mm_go), 0);
        check("t6_rst_vld", longint'(bus.done_vld), 0);
        check("t6_rst_tmo", longint'(bus.tmo_err), 0);
        check("t6_rst_abase", longint'(bus.mm_abase), 0);
        rst_n = 1'b1;
        bus.mm_ret = 1'b1;
        tick();
        bus.mm_ret = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.mm_go || bus.done_vld || bus.busy) seen++;
            tick();
        end
        check("t6_quiet", longint'(seen), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
